// File: rtl/axi_2_hs.sv
// axi_2_hs: AXI4-Lite subordinate that forwards one read or write at a time
// to a simple request/ready handshake peripheral. The hs request is held
// high until the peripheral returns a one-cycle ready pulse, or until the
// timeout expires. A timeout completes the transaction with SLVERR.
module axi_2_hs #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // AXI-Lite read address / read data
    input  logic                  arvalid_i,
    output logic                  arready_o,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [31:0]           rdata_o,
    output logic [1:0]            rresp_o,
    // AXI-Lite write address / write data / write response
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            wstrb_i,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic [1:0]            bresp_o,
    // Handshake-side peripheral interface
    output logic                  hs_read_o,
    output logic                  hs_write_o,
    output logic [ADDR_WIDTH-1:0] hs_addr_o,
    output logic [31:0]           hs_data_o,
    output logic [3:0]            byte_select_o,
    input  logic                  hs_ready_i,
    input  logic [31:0]           hs_data_i
);

    // A zero timeout disables the timeout, but the counter still needs a
    // legal width of at least one bit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        R_RESP,
        WR_COLLECT,
        WR_REQ,
        B_RESP
    } state_t;

    state_t           state;
    logic             aw_got;
    logic             w_got;
    logic             pref_wr;
    logic [CNT_W-1:0] tmo_cnt;

    logic             write_offered;
    logic             ar_hs;
    logic             aw_hs;
    logic             w_hs;
    logic             timed_out;

    // Arbitrate the AXI readies: in IDLE a simultaneous read and write is
    // resolved by pref_wr, which flips after every completed transaction so
    // neither direction can starve the other.
    always_comb begin
        arready_o     = 1'b0;
        awready_o     = 1'b0;
        wready_o      = 1'b0;
        write_offered = awvalid_i | wvalid_i;
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    arready_o = !(write_offered && pref_wr);
                    awready_o = !(arvalid_i && !pref_wr);
                    wready_o  = !(arvalid_i && !pref_wr);
                end
                WR_COLLECT: begin
                    awready_o = !aw_got;
                    wready_o  = !w_got;
                end
                default: begin
                    arready_o = 1'b0;
                    awready_o = 1'b0;
                    wready_o  = 1'b0;
                end
            endcase
        end
    end

    assign ar_hs     = arvalid_i & arready_o;
    assign aw_hs     = awvalid_i & awready_o;
    assign w_hs      = wvalid_i & wready_o;
    assign timed_out = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    // Main transaction FSM; every output except the readies is registered
    // here, and the hs address/data/strobe outputs double as the capture
    // registers for the accepted AXI request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            aw_got        <= 1'b0;
            w_got         <= 1'b0;
            pref_wr       <= 1'b0;
            tmo_cnt       <= '0;
            rvalid_o      <= 1'b0;
            rdata_o       <= '0;
            rresp_o       <= '0;
            bvalid_o      <= 1'b0;
            bresp_o       <= '0;
            hs_read_o     <= 1'b0;
            hs_write_o    <= 1'b0;
            hs_addr_o     <= '0;
            hs_data_o     <= '0;
            byte_select_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        hs_addr_o     <= araddr_i;
                        byte_select_o <= 4'hF;
                        hs_read_o     <= 1'b1;
                        tmo_cnt       <= '0;
                        state         <= RD_REQ;
                    end else begin
                        if (aw_hs) begin
                            hs_addr_o <= awaddr_i;
                        end
                        if (w_hs) begin
                            hs_data_o     <= wdata_i;
                            byte_select_o <= wstrb_i;
                        end
                        if (aw_hs && w_hs) begin
                            hs_write_o <= 1'b1;
                            tmo_cnt    <= '0;
                            state      <= WR_REQ;
                        end else if (aw_hs) begin
                            aw_got <= 1'b1;
                            state  <= WR_COLLECT;
                        end else if (w_hs) begin
                            w_got <= 1'b1;
                            state <= WR_COLLECT;
                        end
                    end
                end

                WR_COLLECT: begin
                    if (aw_hs) begin
                        hs_addr_o <= awaddr_i;
                    end
                    if (w_hs) begin
                        hs_data_o     <= wdata_i;
                        byte_select_o <= wstrb_i;
                    end
                    if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                        aw_got     <= 1'b0;
                        w_got      <= 1'b0;
                        hs_write_o <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= WR_REQ;
                    end
                end

                RD_REQ: begin
                    if (hs_ready_i) begin
                        rdata_o   <= hs_data_i;
                        rresp_o   <= RESP_OKAY;
                        hs_read_o <= 1'b0;
                        rvalid_o  <= 1'b1;
                        state     <= R_RESP;
                    end else if (timed_out) begin
                        rdata_o   <= '0;
                        rresp_o   <= RESP_SLVERR;
                        hs_read_o <= 1'b0;
                        rvalid_o  <= 1'b1;
                        state     <= R_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                WR_REQ: begin
                    if (hs_ready_i) begin
                        bresp_o    <= RESP_OKAY;
                        hs_write_o <= 1'b0;
                        bvalid_o   <= 1'b1;
                        state      <= B_RESP;
                    end else if (timed_out) begin
                        bresp_o    <= RESP_SLVERR;
                        hs_write_o <= 1'b0;
                        bvalid_o   <= 1'b1;
                        state      <= B_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                R_RESP: begin
                    if (rready_i) begin
                        rvalid_o <= 1'b0;
                        pref_wr  <= 1'b1;
                        state    <= IDLE;
                    end
                end

                B_RESP: begin
                    if (bready_i) begin
                        bvalid_o <= 1'b0;
                        pref_wr  <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_2_hs.sv
// tb_axi_2_hs: directed bench for axi_2_hs. An AXI-Lite master and an hs
// peripheral are driven from one linear initial block; expected responses are
// queued when a request is issued and popped when R or B comes back.
module tb_axi_2_hs;

    localparam int AW = 32;

    logic          clk;
    logic          rst;
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic          rvalid;
    logic          rready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          awvalid;
    logic          awready;
    logic [AW-1:0] awaddr;
    logic          wvalid;
    logic          wready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          bvalid;
    logic          bready;
    logic [1:0]    bresp;
    logic          hs_read;
    logic          hs_write;
    logic [AW-1:0] hs_addr;
    logic [31:0]   hs_data_out;
    logic [3:0]    byte_select;
    logic          hs_ready;
    logic [31:0]   hs_data_in;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          is_write;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    axi_2_hs #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .arvalid_i    (arvalid),
        .arready_o    (arready),
        .araddr_i     (araddr),
        .rvalid_o     (rvalid),
        .rready_i     (rready),
        .rdata_o      (rdata),
        .rresp_o      (rresp),
        .awvalid_i    (awvalid),
        .awready_o    (awready),
        .awaddr_i     (awaddr),
        .wvalid_i     (wvalid),
        .wready_o     (wready),
        .wdata_i      (wdata),
        .wstrb_i      (wstrb),
        .bvalid_o     (bvalid),
        .bready_i     (bready),
        .bresp_o      (bresp),
        .hs_read_o    (hs_read),
        .hs_write_o   (hs_write),
        .hs_addr_o    (hs_addr),
        .hs_data_o    (hs_data_out),
        .byte_select_o(byte_select),
        .hs_ready_i   (hs_ready),
        .hs_data_i    (hs_data_in)
    );

    // 100 MHz free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock; inputs are driven and outputs sampled 2 ns after the edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic arv, input logic [AW-1:0] ara,
                                 input logic awv, input logic [AW-1:0] awa,
                                 input logic wv, input logic [31:0] wd,
                                 input logic [3:0] ws);
        arvalid = arv;
        araddr  = ara;
        awvalid = awv;
        awaddr  = awa;
        wvalid  = wv;
        wdata   = wd;
        wstrb   = ws;
    endtask

    // Peripheral model: counts request-high cycles and, if asked to, pulses
    // ready on the (delay+1)-th of them. Returns once the request has dropped.
    task automatic serveHs(input int delay, input logic [31:0] data, input bit respond,
                           output int high);
        high = 0;
        for (int i = 0; i < 40; i++) begin
            if (hs_read || hs_write) begin
                high++;
                if (respond && high == delay + 1) begin
                    hs_ready   = 1'b1;
                    hs_data_in = data;
                end
            end else if (high > 0) begin
                break;
            end
            cyc();
            hs_ready   = 1'b0;
            hs_data_in = '0;
        end
    endtask

    // Wait (bounded) for R or B, compare against the oldest queued expectation,
    // then complete the handshake.
    task automatic awaitResp();
        exp_t e;
        for (int i = 0; i < 20 && !(rvalid || bvalid); i++) begin
            cyc();
        end
        checkOutput("resp_valid", {63'd0, rvalid | bvalid}, 64'd1);
        if (sb.size() == 0) begin
            checkOutput("sb_nonempty", 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            if (e.is_write) begin
                checkOutput("bvalid", {63'd0, bvalid}, 64'd1);
                checkOutput("bresp", {62'd0, bresp}, {62'd0, e.resp});
                bready = 1'b1;
                cyc();
                bready = 1'b0;
                checkOutput("bvalid_drop", {63'd0, bvalid}, 64'd0);
            end else begin
                checkOutput("rvalid", {63'd0, rvalid}, 64'd1);
                checkOutput("rresp", {62'd0, rresp}, {62'd0, e.resp});
                checkOutput("rdata", {32'd0, rdata}, {32'd0, e.data});
                rready = 1'b1;
                cyc();
                rready = 1'b0;
                checkOutput("rvalid_drop", {63'd0, rvalid}, 64'd0);
            end
        end
    endtask

    // Directed sequence
    initial begin
        int high;

        rst        = 1'b1;
        rready     = 1'b0;
        bready     = 1'b0;
        hs_ready   = 1'b0;
        hs_data_in = '0;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        cyc();
        cyc();
        checkOutput("rst_hs_read", {63'd0, hs_read}, 64'd0);
        checkOutput("rst_hs_write", {63'd0, hs_write}, 64'd0);
        checkOutput("rst_rvalid", {63'd0, rvalid}, 64'd0);
        checkOutput("rst_bvalid", {63'd0, bvalid}, 64'd0);
        checkOutput("rst_bytesel", {60'd0, byte_select}, 64'd0);
        rst = 1'b0;
        cyc();

        $display("[TB] read 0x10, ready 3 cycles late, R held off for 5 cycles");
        applyStimulus(1'b1, 32'h10, 1'b0, '0, 1'b0, '0, '0);
        #1;
        checkOutput("rd1_arready", {63'd0, arready}, 64'd1);
        cyc();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        sb.push_back('{1'b0, 2'b00, 32'hDEADBEEF});
        checkOutput("rd1_hs_read", {63'd0, hs_read}, 64'd1);
        checkOutput("rd1_hs_addr", {32'd0, hs_addr}, 64'h10);
        checkOutput("rd1_bytesel", {60'd0, byte_select}, 64'hF);
        checkOutput("rd1_readies", {61'd0, arready, awready, wready}, 64'd0);
        serveHs(3, 32'hDEADBEEF, 1'b1, high);
        checkOutput("rd1_high_cycles", 64'(high), 64'd4);
        for (int i = 0; i < 5; i++) begin
            checkOutput("rd1_hold_rvalid", {63'd0, rvalid}, 64'd1);
            checkOutput("rd1_hold_rdata", {32'd0, rdata}, 64'hDEADBEEF);
            checkOutput("rd1_hold_arready", {63'd0, arready}, 64'd0);
            cyc();
        end
        awaitResp();

        $display("[TB] W two cycles ahead of AW 0x20");
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 32'h12345678, 4'b0011);
        #1;
        checkOutput("wr1_wready", {63'd0, wready}, 64'd1);
        cyc();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        checkOutput("wr1_collect_arready", {63'd0, arready}, 64'd0);
        checkOutput("wr1_collect_wready", {63'd0, wready}, 64'd0);
        checkOutput("wr1_collect_awready", {63'd0, awready}, 64'd1);
        cyc();
        checkOutput("wr1_wait_arready", {63'd0, arready}, 64'd0);
        checkOutput("wr1_wait_hs_write", {63'd0, hs_write}, 64'd0);
        applyStimulus(1'b0, '0, 1'b1, 32'h20, 1'b0, '0, '0);
        #1;
        checkOutput("wr1_awready", {63'd0, awready}, 64'd1);
        cyc();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        sb.push_back('{1'b1, 2'b00, 32'h0});
        checkOutput("wr1_hs_write", {63'd0, hs_write}, 64'd1);
        checkOutput("wr1_hs_addr", {32'd0, hs_addr}, 64'h20);
        checkOutput("wr1_hs_data", {32'd0, hs_data_out}, 64'h12345678);
        checkOutput("wr1_bytesel", {60'd0, byte_select}, 64'h3);
        serveHs(1, 32'h0, 1'b1, high);
        checkOutput("wr1_high_cycles", 64'(high), 64'd2);
        awaitResp();

        $display("[TB] AR and AW+W collide after reset");
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        applyStimulus(1'b1, 32'h30, 1'b1, 32'h40, 1'b1, 32'hCAFEF00D, 4'hF);
        #1;
        checkOutput("col1_arready", {63'd0, arready}, 64'd1);
        checkOutput("col1_awready", {63'd0, awready}, 64'd0);
        cyc();
        arvalid = 1'b0;
        sb.push_back('{1'b0, 2'b00, 32'h11111111});
        checkOutput("col1_hs_read", {63'd0, hs_read}, 64'd1);
        checkOutput("col1_hs_addr", {32'd0, hs_addr}, 64'h30);
        serveHs(0, 32'h11111111, 1'b1, high);
        checkOutput("col1_high_cycles", 64'(high), 64'd1);
        awaitResp();
        // Second collision: a new read appears as the pending write is taken
        arvalid = 1'b1;
        araddr  = 32'h50;
        #1;
        checkOutput("col2_arready", {63'd0, arready}, 64'd0);
        checkOutput("col2_awready", {63'd0, awready}, 64'd1);
        checkOutput("col2_wready", {63'd0, wready}, 64'd1);
        cyc();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        sb.push_back('{1'b1, 2'b00, 32'h0});
        checkOutput("col2_hs_write", {63'd0, hs_write}, 64'd1);
        checkOutput("col2_hs_addr", {32'd0, hs_addr}, 64'h40);
        checkOutput("col2_hs_data", {32'd0, hs_data_out}, 64'hCAFEF00D);
        serveHs(0, 32'h0, 1'b1, high);
        awaitResp();
        #1;
        checkOutput("col2_rd_arready", {63'd0, arready}, 64'd1);
        cyc();
        arvalid = 1'b0;
        sb.push_back('{1'b0, 2'b00, 32'h22222222});
        checkOutput("col2_rd_hs_addr", {32'd0, hs_addr}, 64'h50);
        serveHs(1, 32'h22222222, 1'b1, high);
        awaitResp();

        $display("[TB] timeout with no ready, then ready on the last cycle");
        applyStimulus(1'b1, 32'h60, 1'b0, '0, 1'b0, '0, '0);
        cyc();
        arvalid = 1'b0;
        sb.push_back('{1'b0, 2'b10, 32'h0});
        serveHs(0, 32'h0, 1'b0, high);
        checkOutput("tmo_high_cycles", 64'(high), 64'd8);
        awaitResp();
        applyStimulus(1'b1, 32'h64, 1'b0, '0, 1'b0, '0, '0);
        cyc();
        arvalid = 1'b0;
        sb.push_back('{1'b0, 2'b00, 32'hA5A5A5A5});
        serveHs(7, 32'hA5A5A5A5, 1'b1, high);
        checkOutput("tmo_last_high_cycles", 64'(high), 64'd8);
        awaitResp();

        $display("[TB] reset during a read request");
        applyStimulus(1'b1, 32'h70, 1'b0, '0, 1'b0, '0, '0);
        cyc();
        arvalid = 1'b0;
        checkOutput("rst2_pre_hs_read", {63'd0, hs_read}, 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checkOutput("rst2_hs_read", {63'd0, hs_read}, 64'd0);
        checkOutput("rst2_rvalid", {63'd0, rvalid}, 64'd0);
        checkOutput("rst2_hs_addr", {32'd0, hs_addr}, 64'd0);
        checkOutput("rst2_rdata", {32'd0, rdata}, 64'd0);
        checkOutput("rst2_bytesel", {60'd0, byte_select}, 64'd0);
        applyStimulus(1'b1, 32'h4, 1'b0, '0, 1'b0, '0, '0);
        cyc();
        arvalid = 1'b0;
        sb.push_back('{1'b0, 2'b00, 32'h0BADF00D});
        checkOutput("rd4_hs_addr", {32'd0, hs_addr}, 64'h4);
        serveHs(2, 32'h0BADF00D, 1'b1, high);
        checkOutput("rd4_high_cycles", 64'(high), 64'd3);
        awaitResp();

        $display("[TB] stray hs ready while idle");
        hs_ready   = 1'b1;
        hs_data_in = 32'hFFFFFFFF;
        cyc();
        hs_ready   = 1'b0;
        hs_data_in = '0;
        cyc();
        checkOutput("stray_rvalid", {63'd0, rvalid}, 64'd0);
        checkOutput("stray_bvalid", {63'd0, bvalid}, 64'd0);
        checkOutput("stray_rdata", {32'd0, rdata}, 64'h0BADF00D);
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
